// File: rtl/pkg_rv32_types.sv
// Shared types for the RV32IM single-cycle core.
//  XLEN          machine word width
//  RESET_VECTOR  first fetch address after reset
//  pc_src_e      next-PC select driven into the PC register
//  irq_state_e   RUN/ISR state of the next-PC sequencer
//  CFG_*         register addresses of the sequencer's configuration port
package pkg_rv32_types;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2,
      PC_IRQ    = 2'd3
   } pc_src_e;

   typedef enum logic {
      IRQ_RUN = 1'b0,
      IRQ_ISR = 1'b1
   } irq_state_e;

   localparam logic [1:0] CFG_MASK = 2'd0;
   localparam logic [1:0] CFG_GIE  = 2'd1;
   localparam logic [1:0] CFG_PEND = 2'd2;
   localparam logic [1:0] CFG_EPC  = 2'd3;

endpackage

// File: rtl/rv32_irq_prio_enc.sv
// Fixed-priority encoder for interrupt requests; the lowest index wins.
// Purely combinational.
//  req    in   N_IRQ  request vector (pending & mask)
//  valid  out  1      at least one request is set
//  id     out  5      index of the lowest set request (0 when none)
module rv32_irq_prio_enc
   import pkg_rv32_types::*;
#(
   parameter int N_IRQ = 8
) (
   input  logic [N_IRQ-1:0] req,
   output logic             valid,
   output logic [4:0]       id
);

   // Scan from the highest index down so the last assignment made is
   // the lowest set bit, which gives index 0 the highest priority.
   always_comb begin
      valid = |req;
      id    = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = 5'(i);
         end
      end
   end

endmodule

// File: rtl/rv32_pc_seq.sv
// Next-PC sequencer and interrupt arbiter for the RV32IM single-cycle core.
// Picks the next-PC source each cycle (PC+4, branch, jump, MRET return or
// IRQ entry), latches and prioritises external interrupts, saves the EPC
// and owns the RUN/ISR state machine.
//  clk, rst_n      clock, synchronous active-low reset
//  stall           core/DMA stall, shared with the PC register
//  pc_cur          address of the instruction currently executing
//  branch_taken    conditional branch resolved taken
//  is_jump         JAL/JALR this cycle
//  branch_addr     computed branch/jump target
//  is_mret         MRET decoded this cycle
//  irq_i           external interrupt lines (synchronous)
//  cfg_we/addr/wdata  config write port: 0 mask, 1 gie, 2 pending W1C, 3 epc (RO)
//  cfg_rdata       combinational read of cfg_addr
//  pc_src          next-PC select
//  branch_target   branch_addr, or epc on a return
//  irq_vector      vector of the currently winning IRQ
//  instr_kill      suppress writeback of the current instruction
//  in_isr          sequencer is servicing an interrupt
//  irq_id          id of the interrupt being serviced
module rv32_pc_seq
   import pkg_rv32_types::*;
#(
   parameter int              N_IRQ      = 8,
   parameter logic [XLEN-1:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [XLEN-1:0] VEC_STRIDE = 32'h0000_0010
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic [XLEN-1:0]  pc_cur,
   input  logic             branch_taken,
   input  logic             is_jump,
   input  logic [XLEN-1:0]  branch_addr,
   input  logic             is_mret,
   input  logic [N_IRQ-1:0] irq_i,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      cfg_rdata,
   output pc_src_e          pc_src,
   output logic [XLEN-1:0]  branch_target,
   output logic [XLEN-1:0]  irq_vector,
   output logic             instr_kill,
   output logic             in_isr,
   output logic [4:0]       irq_id
);

   logic [N_IRQ-1:0] irq_q;
   logic [N_IRQ-1:0] pend;
   logic [N_IRQ-1:0] mask;
   logic             gie;
   logic [XLEN-1:0]  epc;
   logic [4:0]       irq_id_q;
   irq_state_e       state;

   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] req;
   logic [N_IRQ-1:0] claim;
   logic [N_IRQ-1:0] w1c;
   logic [N_IRQ-1:0] pend_next;
   logic             win_valid;
   logic [4:0]       win_id;
   logic             take;
   logic             ret;
   logic             cfg_wdata_unused;

   assign cfg_wdata_unused = ^cfg_wdata;

   assign rise = irq_i & ~irq_q;
   assign req  = pend & mask;

   rv32_irq_prio_enc #(
      .N_IRQ (N_IRQ)
   ) u_prio_enc (
      .req   (req),
      .valid (win_valid),
      .id    (win_id)
   );

   assign take = rst_n && (state == IRQ_RUN) && gie && win_valid && !stall;
   assign ret  = rst_n && (state == IRQ_ISR) && is_mret && !stall;

   // Pending bits: the claimed winner and any W1C bits are cleared, but a
   // fresh rising edge in the same cycle always re-sets the bit so no edge
   // is ever lost.
   always_comb begin
      claim = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         claim[i] = take && (win_id == 5'(i));
      end
      w1c       = (cfg_we && (cfg_addr == CFG_PEND)) ? cfg_wdata[N_IRQ-1:0] : '0;
      pend_next = (pend & ~(claim | w1c)) | rise;
   end

   // Next-PC arbitration. An IRQ entry outranks everything in the same
   // cycle, a return from the ISR jumps to the saved EPC, and otherwise
   // the ordinary jump > branch > PC+4 ordering applies in both states.
   // While reset is held the PC register is told to step normally.
   always_comb begin
      pc_src        = PC_PLUS4;
      branch_target = branch_addr;
      instr_kill    = 1'b0;
      if (!rst_n) begin
         pc_src = PC_PLUS4;
      end else if (take) begin
         pc_src     = PC_IRQ;
         instr_kill = 1'b1;
      end else if (ret) begin
         pc_src        = PC_JUMP;
         branch_target = epc;
      end else if (is_jump) begin
         pc_src = PC_JUMP;
      end else if (branch_taken) begin
         pc_src = PC_BRANCH;
      end
   end

   assign irq_vector = VEC_BASE + (XLEN'(win_id) * VEC_STRIDE);
   assign in_isr     = rst_n && (state == IRQ_ISR);
   assign irq_id     = irq_id_q;

   // Config read mux; narrow registers are zero-extended.
   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         CFG_MASK: cfg_rdata = 32'(mask);
         CFG_GIE:  cfg_rdata = {30'b0, in_isr, gie};
         CFG_PEND: cfg_rdata = 32'(pend);
         CFG_EPC:  cfg_rdata = epc;
         default:  cfg_rdata = '0;
      endcase
   end

   // Edge-detect history, pending latch and config registers. The edge
   // detector keeps sampling through stalls so a pulse seen while the core
   // is frozen is still latched as pending.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_q <= '0;
         pend  <= '0;
         mask  <= '0;
         gie   <= 1'b0;
      end else begin
         irq_q <= irq_i;
         pend  <= pend_next;
         if (cfg_we && (cfg_addr == CFG_MASK)) begin
            mask <= cfg_wdata[N_IRQ-1:0];
         end
         if (cfg_we && (cfg_addr == CFG_GIE)) begin
            gie <= cfg_wdata[0];
         end
      end
   end

   // RUN/ISR state machine. Entry saves the interrupted instruction's PC
   // so it re-executes on return; there is no nesting, so ISR only waits
   // for an unstalled MRET.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IRQ_RUN;
         epc      <= '0;
         irq_id_q <= '0;
      end else begin
         case (state)
            IRQ_RUN: begin
               if (take) begin
                  epc      <= pc_cur;
                  irq_id_q <= win_id;
                  state    <= IRQ_ISR;
               end
            end
            IRQ_ISR: begin
               if (ret) begin
                  state <= IRQ_RUN;
               end
            end
            default: state <= IRQ_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_pc_seq.sv
// Self-checking bench for rv32_pc_seq: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the
// sequencer kept in bit arrays and plain integers.
module tb_rv32_pc_seq;
   import pkg_rv32_types::*;

   localparam int          N_IRQ      = 8;
   localparam logic [31:0] VEC_BASE   = 32'h0000_0100;
   localparam logic [31:0] VEC_STRIDE = 32'h0000_0010;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             stall;
   logic [31:0]      pc_cur;
   logic             branch_taken;
   logic             is_jump;
   logic [31:0]      branch_addr;
   logic             is_mret;
   logic [N_IRQ-1:0] irq_i;
   logic             cfg_we;
   logic [1:0]       cfg_addr;
   logic [31:0]      cfg_wdata;
   logic [31:0]      cfg_rdata;
   pc_src_e          pc_src;
   logic [31:0]      branch_target;
   logic [31:0]      irq_vector;
   logic             instr_kill;
   logic             in_isr;
   logic [4:0]       irq_id;

   int n_assert = 0;
   int n_fail   = 0;

   bit          m_isr;
   bit          m_gie;
   bit          m_pend [N_IRQ];
   bit          m_mask [N_IRQ];
   bit          m_prev [N_IRQ];
   logic [31:0] m_epc;
   int          m_id;

   int          e_win;
   bit          e_take;
   bit          e_ret;
   bit          e_isr;
   logic [31:0] e_pc_src;
   logic [31:0] e_target;
   logic [31:0] e_vec;
   logic [31:0] e_rdata;

   rv32_pc_seq #(
      .N_IRQ      (N_IRQ),
      .VEC_BASE   (VEC_BASE),
      .VEC_STRIDE (VEC_STRIDE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .pc_cur        (pc_cur),
      .branch_taken  (branch_taken),
      .is_jump       (is_jump),
      .branch_addr   (branch_addr),
      .is_mret       (is_mret),
      .irq_i         (irq_i),
      .cfg_we        (cfg_we),
      .cfg_addr      (cfg_addr),
      .cfg_wdata     (cfg_wdata),
      .cfg_rdata     (cfg_rdata),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .irq_vector    (irq_vector),
      .instr_kill    (instr_kill),
      .in_isr        (in_isr),
      .irq_id        (irq_id)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      n_assert++;
      assert (obs === expd) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h t=%0t", tag, obs, expd, $time);
      end
   endtask

   // Expected outputs for the current model state and the inputs now applied.
   task automatic predict();
      longint acc;
      e_win = -1;
      for (int i = 0; i < N_IRQ; i++) begin
         if (e_win < 0 && m_pend[i] && m_mask[i]) e_win = i;
      end
      e_isr  = (rst_n === 1'b1) && m_isr;
      e_take = (rst_n === 1'b1) && !m_isr && m_gie && (e_win >= 0) && (stall === 1'b0);
      e_ret  = (rst_n === 1'b1) && m_isr && (is_mret === 1'b1) && (stall === 1'b0);
      if (rst_n !== 1'b1)          e_pc_src = 32'(PC_PLUS4);
      else if (e_take)             e_pc_src = 32'(PC_IRQ);
      else if (e_ret)              e_pc_src = 32'(PC_JUMP);
      else if (is_jump === 1'b1)   e_pc_src = 32'(PC_JUMP);
      else if (branch_taken === 1'b1) e_pc_src = 32'(PC_BRANCH);
      else                         e_pc_src = 32'(PC_PLUS4);
      e_target = e_ret ? m_epc : branch_addr;
      e_vec    = VEC_BASE + 32'(e_win) * VEC_STRIDE;
      acc = 0;
      case (cfg_addr)
         2'd0: for (int i = 0; i < N_IRQ; i++) if (m_mask[i]) acc += longint'(1) << i;
         2'd1: acc = (e_isr ? 2 : 0) + (m_gie ? 1 : 0);
         2'd2: for (int i = 0; i < N_IRQ; i++) if (m_pend[i]) acc += longint'(1) << i;
         default: acc = longint'(m_epc);
      endcase
      e_rdata = 32'(acc);
   endtask

   // Advance the model across one rising clock edge.
   task automatic updateModel();
      bit clr;
      if (rst_n !== 1'b1) begin
         m_isr = 0; m_gie = 0; m_epc = '0; m_id = 0;
         for (int i = 0; i < N_IRQ; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
         end
         return;
      end
      for (int i = 0; i < N_IRQ; i++) begin
         clr = (e_take && e_win == i) || (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]);
         if (irq_i[i] && !m_prev[i]) m_pend[i] = 1;
         else if (clr)               m_pend[i] = 0;
         m_prev[i] = irq_i[i];
         if (cfg_we && cfg_addr == 2'd0) m_mask[i] = cfg_wdata[i];
      end
      if (cfg_we && cfg_addr == 2'd1) m_gie = cfg_wdata[0];
      if (e_take) begin
         m_epc = pc_cur; m_id = e_win; m_isr = 1;
      end else if (e_ret) begin
         m_isr = 0;
      end
   endtask

   task automatic evalCycle(input string tag);
      @(negedge clk);
      predict();
      checkOutput({tag, ".pc_src"}, 32'(pc_src), e_pc_src);
      checkOutput({tag, ".kill"}, 32'(instr_kill), 32'(e_take));
      checkOutput({tag, ".in_isr"}, 32'(in_isr), 32'(e_isr));
      checkOutput({tag, ".target"}, branch_target, e_target);
      checkOutput({tag, ".rdata"}, cfg_rdata, e_rdata);
      if (e_win >= 0) checkOutput({tag, ".vector"}, irq_vector, e_vec);
      if (e_isr)      checkOutput({tag, ".irq_id"}, 32'(irq_id), 32'(m_id));
   endtask

   task automatic applyStimulus();
      predict();
      @(posedge clk);
      updateModel();
      #1;
   endtask

   task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
      cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
      evalCycle("cfg");
      applyStimulus();
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; pc_cur = 32'h0; branch_taken = 1'b0; is_jump = 1'b0;
      branch_addr = 32'h0; is_mret = 1'b0; irq_i = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
      m_isr = 0; m_gie = 0; m_epc = '0; m_id = 0;
      for (int i = 0; i < N_IRQ; i++) begin m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0; end

      $display("[TB] reset state");
      applyStimulus();
      for (int a = 0; a < 4; a++) begin
         cfg_addr = 2'(a);
         evalCycle("rst");
         checkOutput("rst_cfg_zero", cfg_rdata, 32'h0);
         applyStimulus();
      end
      rst_n = 1'b1; pc_cur = 32'h30;

      $display("[TB] pending W1C and set-over-clear");
      irq_i = 8'h01; evalCycle("w1c_a"); applyStimulus();
      irq_i = 8'h00; cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h01;
      evalCycle("w1c_b"); applyStimulus(); cfg_we = 1'b0;
      evalCycle("w1c_c"); checkOutput("w1c_cleared", cfg_rdata, 32'h0); applyStimulus();
      irq_i = 8'h02; cfg_we = 1'b1; cfg_wdata = 32'h02;
      evalCycle("setwin_a"); applyStimulus(); cfg_we = 1'b0; irq_i = 8'h00;
      evalCycle("setwin_b"); checkOutput("set_wins", cfg_rdata, 32'h02); applyStimulus();
      cfgWrite(2'd2, 32'hFF);
      cfgWrite(2'd3, 32'hDEAD_BEEF);
      cfg_addr = 2'd3; evalCycle("epc_ro"); checkOutput("epc_readonly", cfg_rdata, 32'h0); applyStimulus();

      $display("[TB] scenario 1: single IRQ entry");
      cfgWrite(2'd0, 32'h04);
      cfgWrite(2'd1, 32'h01);
      pc_cur = 32'h3C; irq_i = 8'h04;
      evalCycle("t1a"); checkOutput("t1_not_yet", 32'(pc_src), 32'(PC_PLUS4)); applyStimulus();
      irq_i = 8'h00; pc_cur = 32'h40;
      evalCycle("t1b");
      checkOutput("t1_pc_src", 32'(pc_src), 32'(PC_IRQ));
      checkOutput("t1_vector", irq_vector, 32'h120);
      checkOutput("t1_kill", 32'(instr_kill), 32'h1);
      applyStimulus();
      pc_cur = 32'h120; cfg_addr = 2'd3;
      evalCycle("t1c");
      checkOutput("t1_in_isr", 32'(in_isr), 32'h1);
      checkOutput("t1_epc", cfg_rdata, 32'h40);
      checkOutput("t1_irq_id", 32'(irq_id), 32'h2);
      applyStimulus();
      pc_cur = 32'h124; cfgWrite(2'd0, 32'h05);

      $display("[TB] scenario 2: no nesting, MRET, back-to-back take");
      pc_cur = 32'h128; irq_i = 8'h01;
      evalCycle("t2a"); checkOutput("t2_no_nest", 32'(pc_src), 32'(PC_PLUS4)); applyStimulus();
      irq_i = 8'h00; pc_cur = 32'h12C; is_mret = 1'b1;
      evalCycle("t2b");
      checkOutput("t2_mret_src", 32'(pc_src), 32'(PC_JUMP));
      checkOutput("t2_mret_target", branch_target, 32'h40);
      applyStimulus();
      is_mret = 1'b0; pc_cur = 32'h40;
      evalCycle("t2c");
      checkOutput("t2_run", 32'(in_isr), 32'h0);
      checkOutput("t2_take0", 32'(pc_src), 32'(PC_IRQ));
      checkOutput("t2_vec0", irq_vector, 32'h100);
      applyStimulus();
      pc_cur = 32'h100; cfg_addr = 2'd1;
      evalCycle("t2d"); checkOutput("t2_gie_isr", cfg_rdata, 32'h3); applyStimulus();
      is_mret = 1'b1; evalCycle("t2e"); applyStimulus(); is_mret = 1'b0;

      $display("[TB] scenario 3: simultaneous IRQs");
      pc_cur = 32'h44; cfgWrite(2'd0, 32'hFF);
      irq_i = 8'h22; evalCycle("t3a"); applyStimulus(); irq_i = 8'h00;
      pc_cur = 32'h48;
      evalCycle("t3b"); checkOutput("t3_vec1", irq_vector, 32'h110); applyStimulus();
      cfg_addr = 2'd2; pc_cur = 32'h110;
      evalCycle("t3c");
      checkOutput("t3_id1", 32'(irq_id), 32'h1);
      checkOutput("t3_pend5", cfg_rdata, 32'h20);
      applyStimulus();
      is_mret = 1'b1; evalCycle("t3d"); applyStimulus(); is_mret = 1'b0;
      pc_cur = 32'h48;
      evalCycle("t3e");
      checkOutput("t3_take5", 32'(pc_src), 32'(PC_IRQ));
      checkOutput("t3_vec5", irq_vector, 32'h150);
      applyStimulus();
      is_mret = 1'b1; evalCycle("t3f"); applyStimulus(); is_mret = 1'b0;

      $display("[TB] scenario 4: IRQ beats branch");
      pc_cur = 32'h7C; irq_i = 8'h08; evalCycle("t4a"); applyStimulus(); irq_i = 8'h00;
      pc_cur = 32'h80; branch_taken = 1'b1; branch_addr = 32'h200;
      evalCycle("t4b");
      checkOutput("t4_irq_wins", 32'(pc_src), 32'(PC_IRQ));
      checkOutput("t4_vec3", irq_vector, 32'h130);
      applyStimulus();
      branch_taken = 1'b0; cfg_addr = 2'd3;
      evalCycle("t4c"); checkOutput("t4_epc", cfg_rdata, 32'h80); applyStimulus();
      is_mret = 1'b1; evalCycle("t4d"); applyStimulus(); is_mret = 1'b0;

      $display("[TB] scenario 5: stall holds off the take");
      pc_cur = 32'h90; irq_i = 8'h10; evalCycle("t5a"); applyStimulus(); irq_i = 8'h00;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         evalCycle("t5s");
         checkOutput("t5_stall_src", 32'(pc_src), 32'(PC_PLUS4));
         checkOutput("t5_stall_run", 32'(in_isr), 32'h0);
         applyStimulus();
      end
      stall = 1'b0;
      evalCycle("t5b");
      checkOutput("t5_take", 32'(pc_src), 32'(PC_IRQ));
      checkOutput("t5_vec4", irq_vector, 32'h140);
      applyStimulus();

      $display("[TB] scenario 6: reset inside ISR");
      rst_n = 1'b0;
      evalCycle("t6a"); checkOutput("t6_rst_isr", 32'(in_isr), 32'h0); applyStimulus();
      rst_n = 1'b1; is_mret = 1'b1; cfg_addr = 2'd2;
      evalCycle("t6b");
      checkOutput("t6_mret_run", 32'(pc_src), 32'(PC_PLUS4));
      checkOutput("t6_pend0", cfg_rdata, 32'h0);
      applyStimulus();
      cfg_addr = 2'd0;
      evalCycle("t6c"); checkOutput("t6_mask0", cfg_rdata, 32'h0); applyStimulus();
      is_mret = 1'b0;

      $display("[TB] randomized phase");
      cfgWrite(2'd0, 32'hFF);
      cfgWrite(2'd1, 32'h01);
      for (int n = 0; n < 400; n++) begin
         rst_n        = ($urandom_range(0, 63) != 0);
         stall        = ($urandom_range(0, 3) == 0);
         irq_i        = irq_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         is_mret      = ($urandom_range(0, 5) == 0);
         is_jump      = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 3) == 0);
         pc_cur       = $urandom & 32'hFFFF_FFFC;
         branch_addr  = $urandom;
         cfg_we       = ($urandom_range(0, 7) == 0);
         cfg_addr     = 2'($urandom);
         cfg_wdata    = (cfg_addr == 2'd1) ? 32'($urandom_range(0, 3) != 0) : $urandom;
         evalCycle("rnd");
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
